// File: rtl/ped_request_conditioner_pkg.sv
// Shared traffic-light definitions.
// State encoding and board-level constants.
package ped_request_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUESTED = 2'd1,
    LOCKOUT   = 2'd2
  } ped_state_t;

  localparam int   TICK_12MHZ = 12_000_000;
  localparam logic LED_ON     = 1'b0;

endpackage

// File: rtl/ped_request_conditioner_btn_debounce.sv
// Push-button synchronizer and debouncer.
// Emits a clean level and a press strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press
);

  localparam int   CW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic AL  = (BTN_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          s2_n;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer, parked at the released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= AL;
      s2 <= AL;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  assign s2_n = s2 ^ AL;

  // Accept a new level only after it held long enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (s2_n == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2_n;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign btn_clean = stable;
  assign press     = stable & ~stable_d;

endmodule

// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner.
// Holds a request until served, then locks out.
module ped_request_conditioner
  import ped_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int TICK_CYCLES     = TICK_12MHZ,
  parameter int LOCKOUT_SEC     = 5,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       cycle_done,
  output logic       req,
  output logic       req_pulse,
  output logic       btn_clean,
  output logic       pending_led,
  output logic       lockout,
  output logic [7:0] press_cnt
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int SW = (LOCKOUT_SEC < 1) ? 1
                    : $clog2(LOCKOUT_SEC + 1);
  localparam logic NO_LOCK = (LOCKOUT_SEC == 0);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SEC_LAST =
    SW'((LOCKOUT_SEC > 0) ? LOCKOUT_SEC - 1 : 0);

  ped_state_t    state;
  ped_state_t    nstate;
  logic          press;
  logic          pending;
  logic          pend_n;
  logic          pulse_n;
  logic          req_n;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_n;
  logic [SW-1:0] sec;
  logic [SW-1:0] sec_n;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .press    (press)
  );

  // Next state, pending flag and lockout timing
  always_comb begin
    nstate  = state;
    pend_n  = pending;
    pulse_n = 1'b0;
    tick_n  = tick;
    sec_n   = sec;
    unique case (state)
      IDLE: begin
        if (press) begin
          nstate  = REQUESTED;
          pulse_n = 1'b1;
        end
      end
      REQUESTED: begin
        if (cycle_done) begin
          if (NO_LOCK) begin
            nstate  = press ? REQUESTED : IDLE;
            pulse_n = press;
          end else begin
            nstate = LOCKOUT;
            pend_n = press;
            tick_n = '0;
            sec_n  = '0;
          end
        end
      end
      LOCKOUT: begin
        if (tick == TICK_LAST) begin
          tick_n = '0;
          sec_n  = sec + SW'(1);
        end else begin
          tick_n = tick + TW'(1);
        end
        if (tick == TICK_LAST && sec == SEC_LAST) begin
          nstate  = (pending | press) ? REQUESTED : IDLE;
          pulse_n = pending | press;
          pend_n  = 1'b0;
        end else if (press) begin
          pend_n = 1'b1;
        end
      end
      default: begin
        nstate = IDLE;
        pend_n = 1'b0;
      end
    endcase
  end

  assign req_n = (nstate == REQUESTED);

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      tick        <= '0;
      sec         <= '0;
      req         <= 1'b0;
      req_pulse   <= 1'b0;
      lockout     <= 1'b0;
      pending_led <= ~LED_ON;
    end else begin
      state       <= nstate;
      pending     <= pend_n;
      tick        <= tick_n;
      sec         <= sec_n;
      req         <= req_n;
      req_pulse   <= pulse_n;
      lockout     <= (nstate == LOCKOUT);
      pending_led <= (req_n | pend_n) ? LED_ON : ~LED_ON;
    end
  end

  // Saturating count of accepted presses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_cnt <= 8'd0;
    end else if (press && press_cnt != 8'hFF) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Testbench for ped_request_conditioner.
// Table vectors, corner sequences, random vs model.
module tb_ped_request_conditioner;

  localparam int DEB  = 4;
  localparam int TCK  = 10;
  localparam int LSEC = 2;
  localparam int LLEN = LSEC * TCK;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       cycle_done;
  logic       req;
  logic       req_pulse;
  logic       btn_clean;
  logic       pending_led;
  logic       lockout;
  logic [7:0] press_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TCK),
    .LOCKOUT_SEC    (LSEC),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .cycle_done (cycle_done),
    .req        (req),
    .req_pulse  (req_pulse),
    .btn_clean  (btn_clean),
    .pending_led(pending_led),
    .lockout    (lockout),
    .press_cnt  (press_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic m_hist [0:DEB+1];
  logic m_stab, m_stab_old;
  logic m_req, m_pulse, m_pend, m_lock;
  int   m_lstart;
  int   m_cnt;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d",
                  nm, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i <= DEB + 1; i++) m_hist[i] = 1'b0;
    m_stab = 0; m_stab_old = 0;
    m_req = 0; m_pulse = 0; m_pend = 0; m_lock = 0;
    m_lstart = 0; m_cnt = 0;
  endtask

  // Button accepted when the sample seen by the
  // debouncer differed from it for DEB edges in a row.
  task automatic model_step(input logic b, input logic c);
    logic p;
    logic flip;
    for (int i = DEB + 1; i > 0; i--)
      m_hist[i] = m_hist[i-1];
    m_hist[0] = ~b;
    p = m_stab & ~m_stab_old;
    m_stab_old = m_stab;
    flip = 1'b1;
    for (int j = 2; j <= DEB + 1; j++)
      if (m_hist[j] == m_stab) flip = 1'b0;
    if (flip) m_stab = ~m_stab;
    m_pulse = 1'b0;
    if (m_lock) begin
      if (cyc == m_lstart + LLEN) begin
        m_lock = 1'b0;
        if (m_pend | p) begin
          m_req = 1'b1; m_pulse = 1'b1;
        end
        m_pend = 1'b0;
      end else if (p) begin
        m_pend = 1'b1;
      end
    end else if (m_req) begin
      if (c) begin
        m_req = 1'b0; m_lock = 1'b1;
        m_lstart = cyc; m_pend = p;
      end
    end else if (p) begin
      m_req = 1'b1; m_pulse = 1'b1;
    end
    if (p && m_cnt < 255) m_cnt++;
  endtask

  task automatic tick(input logic b, input logic c);
    logic [12:0] act, exp;
    btn_raw = b;
    cycle_done = c;
    @(posedge clk);
    #1;
    cyc++;
    model_step(b, c);
    act = {req, req_pulse, btn_clean, lockout,
           pending_led, press_cnt};
    exp = {m_req, m_pulse, m_stab, m_lock,
           ~(m_req | m_pend), 8'(m_cnt)};
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL model cyc=%0d got=%h want=%h",
                  cyc, act, exp);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, int'(req), 0);
    chk({nm, "_pulse"}, int'(req_pulse), 0);
    chk({nm, "_clean"}, int'(btn_clean), 0);
    chk({nm, "_lock"}, int'(lockout), 0);
    chk({nm, "_led"}, int'(pending_led), 1);
    chk({nm, "_cnt"}, int'(press_cnt), 0);
  endtask

  typedef struct {
    int   n;
    logic b;
    logic c;
    logic rq;
    logic pl;
    logic cl;
    logic lk;
    logic ld;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int x;
    int s;
    int rise;
    logic [12:0] got, want;

    tbl.push_back('{9, 1, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{5, 0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{3, 0, 0, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{5, 1, 0, 1, 0, 1, 0, 0, 1});
    tbl.push_back('{3, 1, 0, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 1, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{19, 1, 0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{4, 1, 0, 0, 0, 0, 0, 1, 1});

    rst = 1'b0;
    btn_raw = 1'b1;
    cycle_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;

    // Clean press, service and lockout
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        tick(tbl[r].b, tbl[r].c);
        got  = {req, req_pulse, btn_clean, lockout,
                pending_led, press_cnt};
        want = {tbl[r].rq, tbl[r].pl, tbl[r].cl,
                tbl[r].lk, tbl[r].ld, 8'(tbl[r].cnt)};
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL table row=%0d cyc=%0d got=%h want=%h",
                      r, cyc, got, want);
      end
    end

    // Bounce: only the final held low is accepted
    repeat (3) tick(1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b0);
    s = cyc + 1;
    rise = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      if (rise < 0 && btn_clean) rise = cyc;
    end
    chk("bounce_latency", rise, s + 5);
    chk("bounce_count", int'(press_cnt), 2);
    repeat (8) tick(1'b1, 1'b0);

    // Press accepted during lockout cycle 5
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    x = cyc;
    repeat (5) tick(1'b0, 1'b0);
    chk("lk_pend_led", int'(pending_led), 0);
    chk("lk_active", int'(lockout), 1);
    repeat (14) tick(1'b0, 1'b0);
    chk("lk_still_low", int'(req), 0);
    tick(1'b0, 1'b0);
    chk("lk_exit_cyc", cyc - x, LLEN);
    chk("lk_exit_req", int'(req), 1);
    chk("lk_exit_pulse", int'(req_pulse), 1);
    chk("lk_exit_lock", int'(lockout), 0);
    chk("lk_cnt", int'(press_cnt), 3);
    tick(1'b0, 1'b0);
    chk("lk_pulse_1cyc", int'(req_pulse), 0);

    // Press event on the same edge as cycle_done
    repeat (8) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    x = cyc;
    chk("sim_lock", int'(lockout), 1);
    chk("sim_led", int'(pending_led), 0);
    chk("sim_req", int'(req), 0);
    chk("sim_cnt", int'(press_cnt), 4);
    repeat (LLEN) tick(1'b0, 1'b0);
    chk("sim_rereq", int'(req & req_pulse), 1);

    // Reset while locked out with a pending press
    repeat (8) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b0);
    chk("rst_pre_led", int'(pending_led), 0);
    chk("rst_pre_lock", int'(lockout), 1);
    btn_raw = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) tick(1'b1, 1'b0);
    chk("rst_no_req", int'(req), 0);

    // 300 accepted presses saturate the counter
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(5, 8))
        tick(1'b0, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(5, 8))
        tick(1'b1, $urandom_range(0, 9) == 0);
    end
    chk("sat_cnt", int'(press_cnt), 255);

    // Random glitchy button against the model
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(1, 7))
        tick(1'($urandom_range(0, 1)),
             $urandom_range(0, 11) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
Upstream stage of the traffic-light controller. Conditions the raw pedestrian push-button: synchronizes it, debounces it, detects the press edge and holds a request level until the controller reports that the crossing sequence has finished. After each served cycle it enforces a lockout period. A press during lockout is remembered and re-issued when the lockout ends. It also drives the "request pending" LED and a press counter.

Parameters:
DEBOUNCE_CYCLES, 240000, cycles the synchronized input must stay stable before it is accepted (20 ms at 12 MHz); minimum 2.
TICK_CYCLES, 12000000, clock cycles per lockout second; minimum 2.
LOCKOUT_SEC, 5, whole seconds after cycle_done during which new requests are not issued; 0 disables lockout.
BTN_ACTIVE_LOW, 1, 1 = btn_raw low means pressed; 0 = high means pressed.

Ports:
clk  in  1  system clock (12 MHz)
rst  in  1  asynchronous, active-low reset
btn_raw  in  1  asynchronous push-button pin
cycle_done  in  1  1-cycle pulse from the controller: crossing sequence finished, count wrapped
req  out  1  request level to the controller; high from accepted press until cycle_done
req_pulse  out  1  1-cycle strobe coinciding with each 0->1 transition of req
btn_clean  out  1  debounced button, active-high (1 = pressed)
pending_led  out  1  active-low LED: 0 while req=1 or a press is held during lockout
lockout  out  1  high while in LOCKOUT
press_cnt  out  8  accepted presses since reset, saturates at 255

Behaviour:
- Reset (rst=0, async): sync flops, stable, btn_clean, req, req_pulse, lockout, pending flag, all counters = 0; pending_led = 1 (off); state = IDLE. Sync flops reset to the not-pressed level.
- Sync: 2-FF synchronizer, polarity normalized to pressed = 1 after the second flop (s2).
- Debounce: if s2 == stable, cnt <= 0. Otherwise, if cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0; else cnt++. btn_clean = stable.
- Latency: if btn_raw is first sampled pressed at edge E and held, btn_clean rises at edge E+DEBOUNCE_CYCLES+1. A press event (registered rising edge of stable) occurs at edge E+DEBOUNCE_CYCLES+2.
- Glitches shorter than DEBOUNCE_CYCLES cycles at s2 are ignored. Release is debounced identically and generates no event.
- Each press event increments press_cnt (saturating), in every state.
- FSM states:
  - IDLE: press event -> REQUESTED; req <= 1, req_pulse <= 1 on the same edge. cycle_done is ignored.
  - REQUESTED: req = 1. Further presses are absorbed (counted only). cycle_done -> LOCKOUT (or IDLE if LOCKOUT_SEC = 0); req <= 0.
  - LOCKOUT: lockout = 1. A press event sets the pending flag. A tick counter counts 0..TICK_CYCLES-1 and increments a second counter on wrap. When the second counter reaches LOCKOUT_SEC, exit on that edge; total duration is exactly LOCKOUT_SEC*TICK_CYCLES cycles. Exit target:
    - pending = 1 -> REQUESTED with req <= 1 and req_pulse <= 1; pending cleared.
    - pending = 0 -> IDLE.
    - cycle_done is ignored.
- Simultaneous events:
  - Press event and cycle_done in REQUESTED on the same edge: go to LOCKOUT with pending = 1 (or straight back to REQUESTED with a new req_pulse if LOCKOUT_SEC = 0).
  - Press event on the LOCKOUT exit edge: counts as pending.
- Tick and second counters are cleared on LOCKOUT entry. Their widths are ceil(log2(TICK_CYCLES)) and ceil(log2(LOCKOUT_SEC+1)) (minimum 1).
- pending_led = ~(req | pending), registered.
- Reset asserted mid-operation (any state) returns all outputs to reset values immediately; no request survives reset.

Decomposition:
- Shared traffic-light package: FSM state encoding (IDLE, REQUESTED, LOCKOUT), the 12 MHz tick constant, and the LED-on = 0 polarity constant.
- One natural sub-module: btn_debounce (sync + debounce + rising-edge strobe), parameterized by DEBOUNCE_CYCLES and BTN_ACTIVE_LOW.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, LOCKOUT_SEC=2, BTN_ACTIVE_LOW=1.
1. Clean press: btn_raw 1->0 sampled first at edge 10, held -> btn_clean=1 at edge 15; req=1 and req_pulse=1 (one cycle) at edge 16; press_cnt=1; pending_led=0.
2. Bounce: btn_raw low for 3 cycles, high for 2, low held -> no early acceptance; btn_clean rises 5 edges after the final low is first sampled; exactly one press event.
3. Service and lockout: in REQUESTED, pulse cycle_done -> req=0 and lockout=1 next edge; lockout=1 for exactly 20 cycles, then IDLE with pending_led=1.
4. Press during lockout: accepted press at lockout cycle 5 -> pending_led=0; at lockout exit req=1, req_pulse=1 on the same edge; press_cnt increments once.
5. Simultaneous press event and cycle_done in REQUESTED -> LOCKOUT entered with pending=1; re-request after 20 cycles.
6. Reset mid-LOCKOUT with pending set -> all outputs at reset values; after release, no req without a new press. Separately, 300 presses -> press_cnt=255.
